// File: rtl/lock_code_sender_pkg.sv
// Shared definitions for the lock serial code interface: FSM states and
// default line values, so the sender and the lock agree on encodings.
package lock_code_sender_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_RESYNC,
      ST_DONE
   } state_t;

   localparam int unsigned DEF_CODE_LEN   = 3;
   localparam int unsigned DEF_MAX_TRY    = 3;
   localparam logic        DEF_IDLE_BIT   = 1'b0;
   localparam logic        DEF_RESYNC_BIT = 1'b1;

endpackage

// File: rtl/lock_code_shreg.sv
// Loadable MSB-first shift register feeding the serial code line.
module lock_code_shreg #(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] data,
   output logic             bit_out
);

   logic [WIDTH-1:0] sr;

   // Load has priority over shift; zeros are shifted in behind the word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        sr <= '0;
      else if (load)  sr <= data;
      else if (shift) sr <= {sr[WIDTH-2:0], 1'b0};
   end

   assign bit_out = sr[WIDTH-1];

endmodule

// File: rtl/lock_code_sender.sv
// Serial code transmitter for the electronic lock: sends a latched code word
// MSB first, samples the lock's Mealy response during the last bit, and
// retries with a one-cycle resync bit up to MAX_TRY attempts.
module lock_code_sender
   import lock_code_sender_pkg::*;
#(
   parameter int unsigned CODE_LEN   = DEF_CODE_LEN,
   parameter int unsigned MAX_TRY    = DEF_MAX_TRY,
   parameter logic        IDLE_BIT   = DEF_IDLE_BIT,
   parameter logic        RESYNC_BIT = DEF_RESYNC_BIT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [CODE_LEN-1:0]          code_word,
   input  logic                         open_lock,
   input  logic                         alarm,
   output logic                         code,
   output logic                         busy,
   output logic                         done,
   output logic                         success,
   output logic                         fail,
   output logic [$clog2(MAX_TRY+1)-1:0] tries,
   output logic                         alarm_seen
);

   localparam int unsigned TW = $clog2(MAX_TRY + 1);
   localparam int unsigned CW = $clog2(CODE_LEN + 1);

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;      // bits still to be put on the line
   logic [TW-1:0]       tries_q, tries_d;
   logic [CODE_LEN-1:0] word_q;
   logic                code_q, code_d;
   logic                ok_q, ok_d;
   logic                alarm_q;
   logic                accept, load, shift, bit_out;
   logic [CODE_LEN-1:0] sh_data;

   // Fresh word on accept, latched copy on every retry reload.
   assign sh_data = (state_q == ST_IDLE) ? code_word : word_q;

   lock_code_shreg #(
      .WIDTH (CODE_LEN)
   ) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (shift),
      .data    (sh_data),
      .bit_out (bit_out)
   );

   // State, counters and the registered code line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tries_q <= '0;
         code_q  <= IDLE_BIT;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tries_q <= tries_d;
         code_q  <= code_d;
         ok_q    <= ok_d;
      end
   end

   // Latched copy of the accepted word for retries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         word_q <= '0;
      else if (accept) word_q <= code_word;
   end

   // Sticky alarm flag, sampled while busy and cleared on a new request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 alarm_q <= 1'b0;
      else if (accept)         alarm_q <= 1'b0;
      else if (busy && alarm)  alarm_q <= 1'b1;
   end

   // Next-state logic. The shift register is reloaded on the rejecting edge
   // so the MSB can be driven straight out of RESYNC with no gap cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tries_d = tries_q;
      code_d  = IDLE_BIT;
      ok_d    = ok_q;
      accept  = 1'b0;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept  = 1'b1;
               load    = 1'b1;
               cnt_d   = CW'(CODE_LEN);
               tries_d = '0;
               ok_d    = 1'b0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (cnt_q != '0) begin
               code_d = bit_out;
               shift  = 1'b1;
               cnt_d  = cnt_q - 1'b1;
            end else begin
               tries_d = tries_q + 1'b1;
               if (open_lock) begin
                  ok_d    = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  load    = 1'b1;
                  code_d  = RESYNC_BIT;
                  state_d = ST_RESYNC;
               end
            end
         end
         ST_RESYNC: begin
            if (tries_q == TW'(MAX_TRY)) begin
               state_d = ST_DONE;
            end else begin
               code_d  = bit_out;
               shift   = 1'b1;
               cnt_d   = CW'(CODE_LEN - 1);
               state_d = ST_SEND;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign code       = code_q;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign success    = done & ok_q;
   assign fail       = done & ~ok_q;
   assign tries      = tries_q;
   assign alarm_seen = alarm_q;

endmodule
